// File: rtl/vn_collector_pkg.sv
// Shared widths and the {word, lane} entry type used by the VN collector and its compactor.
// The entry struct is sized from the package widths, so instances must use these widths.
package vn_collector_pkg;
    localparam int VN_DATA_W     = 32;
    localparam int VN_NUM_LANES  = 4;
    localparam int VN_FIFO_DEPTH = 8;
    localparam int VN_LANE_W     = (VN_NUM_LANES > 1) ? $clog2(VN_NUM_LANES) : 1;
    localparam int VN_CNT_W      = $clog2(VN_FIFO_DEPTH + 1);
    localparam int VN_N_W        = $clog2(VN_NUM_LANES + 1);

    typedef struct packed {
        logic [VN_DATA_W-1:0] word;
        logic [VN_LANE_W-1:0] lane;
    } vn_entry_t;
endpackage

// File: rtl/vn_lane_compactor.sv
// Packs the valid lanes of one cycle, lowest lane first, into a dense entry list plus count.
module vn_lane_compactor
    import vn_collector_pkg::*;
#(
    parameter int DATA_TYPE = VN_DATA_W,
    parameter int NUM_LANES = VN_NUM_LANES
) (
    input  logic [DATA_TYPE*NUM_LANES-1:0] vn,
    input  logic [NUM_LANES-1:0]           valid,
    output vn_entry_t [NUM_LANES-1:0]      entries,
    output logic [VN_N_W-1:0]              n
);
    logic [VN_N_W-1:0] idx;

    always_comb begin
        entries = '0;
        idx     = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (valid[k]) begin
                entries[idx[VN_LANE_W-1:0]].word = vn[k*DATA_TYPE +: DATA_TYPE];
                entries[idx[VN_LANE_W-1:0]].lane = VN_LANE_W'(k);
                idx = idx + 1'b1;
            end
        end
        n = idx;
    end
endmodule

// File: rtl/vn_collector.sv
// Collects sparse per-lane VN words into a first-word-fall-through buffer; a lane group
// that does not fit is dropped whole and flagged in a sticky overflow bit.
module vn_collector
    import vn_collector_pkg::*;
#(
    parameter int DATA_TYPE  = VN_DATA_W,
    parameter int NUM_LANES  = VN_NUM_LANES,
    parameter int FIFO_DEPTH = VN_FIFO_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_TYPE*NUM_LANES-1:0]     i_vn,
    input  logic [NUM_LANES-1:0]               i_vn_valid,
    input  logic                               i_clear,
    output logic [DATA_TYPE-1:0]               o_data,
    output logic [$clog2(NUM_LANES)-1:0]       o_lane,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count,
    output logic                               o_overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    vn_entry_t [NUM_LANES-1:0] entries;
    logic [VN_N_W-1:0]         n;
    vn_entry_t                 mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          rd_ptr, wr_ptr;
    logic [CNT_W-1:0]          count;
    logic                      overflow;
    logic                      pop, push, drop;
    logic [CNT_W:0]            free;

    vn_lane_compactor #(.DATA_TYPE(DATA_TYPE), .NUM_LANES(NUM_LANES)) u_compactor (
        .vn      (i_vn),
        .valid   (i_vn_valid),
        .entries (entries),
        .n       (n)
    );

    // A same-cycle pop frees one slot, so a full buffer can still take a single entry.
    assign pop  = (count != '0) && i_ready;
    assign free = (CNT_W+1)'(FIFO_DEPTH) - (CNT_W+1)'(count) + (CNT_W+1)'(pop);
    assign push = (n != '0) && ((CNT_W+1)'(n) <= free);
    assign drop = (n != '0) && ((CNT_W+1)'(n) >  free);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(n);
            if (drop)
                overflow <= 1'b1;
            count <= count + (push ? CNT_W'(n) : CNT_W'(0)) - CNT_W'(pop);
        end
    end

    // Storage is left unreset; stale contents are hidden by the empty mask below.
    always_ff @(posedge clk) begin
        if (!rst && !i_clear && push) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (k < int'(n))
                    mem[wr_ptr + PTR_W'(k)] <= entries[k];
            end
        end
    end

    assign o_valid    = (count != '0);
    assign o_data     = o_valid ? mem[rd_ptr].word : '0;
    assign o_lane     = o_valid ? mem[rd_ptr].lane : '0;
    assign o_count    = count;
    assign o_overflow = overflow;
endmodule
